spi_reg_ctrl: RTL

Byte-level transaction controller that sits directly above `spi_slave`. It turns the slave's raw rx/tx byte handshakes into a register-access protocol over a bank of `NUM_REGS` 8-bit registers. The first byte of each SS_n frame is a command; every following byte is a write or a read, with the register address auto-incrementing. It drives the slave's `tx_data`/`tx_start` so MISO carries an ID byte during the command and register contents during reads.

---
 rtl/spi_reg_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/spi_reg_ctrl.sv
// Register-access protocol over spi_slave byte handshakes: command byte, then auto-incrementing reg writes/reads.
// Writes land 1 clk after rx_done; tx_start fires 1 clk after tx_ready with a byte pending, and is held off otherwise.
module spi_reg_ctrl #(
  parameter int         NUM_REGS = 4,
  parameter int         ADDR_W   = $clog2(NUM_REGS),
  parameter logic [7:0] ID_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SS_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_done,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  output logic [NUM_REGS*8-1:0] reg_q,
  output logic                  wr_strobe,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic                  frame_active
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WR, S_RD} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cmd_addr;
  logic              pend_q, pend_d;
  logic [7:0]        pend_dat_q, pend_dat_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        regs_q [NUM_REGS];
  logic [7:0]        regs_d [NUM_REGS];

  assign cmd_addr = rx_data[ADDR_W-1:0];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pend_d      = pend_q;
    pend_dat_d  = pend_dat_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    regs_d      = regs_q;

    if (SS_n) begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
    end else begin
      // tx_data is captured at issue time so a same-cycle prefetch cannot disturb it
      if (pend_q && tx_ready && !tx_start_q) begin
        tx_start_d = 1'b1;
        tx_data_d  = pend_dat_q;
        pend_d     = 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          state_d    = S_CMD;
          pend_d     = 1'b1;
          pend_dat_d = ID_BYTE;
        end
        S_CMD: begin
          if (rx_done) begin
            pend_d = 1'b1;
            if (rx_data[7]) begin
              state_d    = S_WR;
              addr_d     = cmd_addr;
              pend_dat_d = 8'h00;
            end else begin
              state_d    = S_RD;
              pend_dat_d = regs_q[cmd_addr];
              addr_d     = cmd_addr + 1'b1;
            end
          end
        end
        S_WR: begin
          if (rx_done) begin
            regs_d[addr_q] = rx_data;
            wr_strobe_d    = 1'b1;
            wr_addr_d      = addr_q;
            addr_d         = addr_q + 1'b1;
            pend_d         = 1'b1;
            pend_dat_d     = 8'h00;
          end
        end
        S_RD: begin
          if (tx_start_q) begin
            pend_d     = 1'b1;
            pend_dat_d = regs_q[addr_q];
            addr_d     = addr_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      pend_q      <= 1'b0;
      pend_dat_q  <= 8'h00;
      tx_data_q   <= 8'h00;
      tx_start_q  <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pend_q      <= pend_d;
      pend_dat_q  <= pend_dat_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      regs_q      <= regs_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_q[8*g +: 8] = regs_q[g];
  end

  assign tx_data      = tx_data_q;
  assign tx_start     = tx_start_q;
  assign wr_strobe    = wr_strobe_q;
  assign wr_addr      = wr_addr_q;
  assign frame_active = (state_q != S_IDLE);

endmodule
